// File: rtl/uart_digit_rx_pkg.sv
// Shared types and constants for the UART decimal-digit receiver.
package uart_digit_rx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  localparam logic [7:0] ASCII_0 = 8'h30;
  localparam logic [7:0] ASCII_9 = 8'h39;

  localparam int unsigned DEF_CLK_PER_BIT  = 8;
  localparam int unsigned DEF_NUM_DIGITS   = 7;
  localparam int unsigned DEF_TIMEOUT_BITS = 20;

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= ASCII_0) && (b <= ASCII_9);
  endfunction

endpackage

// File: rtl/uart_byte_rx.sv
// 8N1 UART byte receiver: input synchronizer, start-bit qualification,
// LSB-first data capture and stop-bit check.
module uart_byte_rx
  import uart_digit_rx_pkg::*;
#(
  parameter int unsigned CLK_PER_BIT = DEF_CLK_PER_BIT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_data,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       stop_err,
  output logic       busy
);

  localparam int unsigned CNT_W = $clog2(CLK_PER_BIT);
  localparam int unsigned HALF  = CLK_PER_BIT / 2;

  logic             sync1, sync2, line_q;
  logic             fall;
  rx_state_t        state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [2:0]       bit_idx, bit_nxt;
  logic [7:0]       shreg, shreg_nxt;
  logic [7:0]       rx_byte_nxt;
  logic             byte_valid_nxt, stop_err_nxt, busy_nxt;

  assign fall = line_q & ~sync2;

  // Synchronizer plus one delayed copy for falling-edge detection; idle high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1  <= 1'b1;
      sync2  <= 1'b1;
      line_q <= 1'b1;
    end else begin
      sync1  <= uart_data;
      sync2  <= sync1;
      line_q <= sync2;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      rx_byte    <= '0;
      byte_valid <= 1'b0;
      stop_err   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      bit_idx    <= bit_nxt;
      shreg      <= shreg_nxt;
      rx_byte    <= rx_byte_nxt;
      byte_valid <= byte_valid_nxt;
      stop_err   <= stop_err_nxt;
      busy       <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    bit_nxt        = bit_idx;
    shreg_nxt      = shreg;
    rx_byte_nxt    = rx_byte;
    byte_valid_nxt = 1'b0;
    stop_err_nxt   = 1'b0;

    unique case (state)
      IDLE: begin
        if (fall) begin
          state_nxt = START;
          cnt_nxt   = '0;
        end
      end
      // Mid-start-bit resample rejects short glitches.
      START: begin
        if (cnt == CNT_W'(HALF - 1)) begin
          cnt_nxt   = '0;
          bit_nxt   = '0;
          state_nxt = sync2 ? IDLE : DATA;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt == CNT_W'(CLK_PER_BIT - 1)) begin
          cnt_nxt   = '0;
          shreg_nxt = {sync2, shreg[7:1]};
          bit_nxt   = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_nxt = STOP;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      STOP: begin
        if (cnt == CNT_W'(CLK_PER_BIT - 1)) begin
          cnt_nxt   = '0;
          state_nxt = IDLE;
          if (sync2) begin
            byte_valid_nxt = 1'b1;
            rx_byte_nxt    = shreg;
          end else begin
            stop_err_nxt = 1'b1;
          end
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase

    busy_nxt = (state_nxt != IDLE);
  end

endmodule

// File: rtl/uart_digit_rx.sv
// Receives ASCII decimal digits over UART into a BCD shift register and
// flags complete NUM_DIGITS packets; partial packets expire after idle time.
module uart_digit_rx
  import uart_digit_rx_pkg::*;
#(
  parameter int unsigned CLK_PER_BIT  = DEF_CLK_PER_BIT,
  parameter int unsigned NUM_DIGITS   = DEF_NUM_DIGITS,
  parameter int unsigned TIMEOUT_BITS = DEF_TIMEOUT_BITS
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    uart_data,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic                    digit_valid,
  output logic                    packet_valid,
  output logic                    frame_err,
  output logic                    char_err,
  output logic                    busy
);

  localparam int unsigned DW         = 4 * NUM_DIGITS;
  localparam int unsigned CNT_W      = $clog2(NUM_DIGITS + 1);
  localparam int unsigned IDLE_LIMIT = TIMEOUT_BITS * CLK_PER_BIT;
  localparam int unsigned IDLE_W     = $clog2(IDLE_LIMIT + 1);

  logic [7:0]        rx_byte;
  logic              byte_valid, stop_err;
  logic [CNT_W-1:0]  digit_cnt;
  logic [IDLE_W-1:0] idle_cnt;

  uart_byte_rx #(
    .CLK_PER_BIT (CLK_PER_BIT)
  ) u_byte_rx (
    .clk        (clk),
    .rst        (rst),
    .uart_data  (uart_data),
    .rx_byte    (rx_byte),
    .byte_valid (byte_valid),
    .stop_err   (stop_err),
    .busy       (busy)
  );

  // Digit parsing, packet counting and idle timeout; idle counter saturates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digits       <= '0;
      digit_cnt    <= '0;
      idle_cnt     <= '0;
      digit_valid  <= 1'b0;
      packet_valid <= 1'b0;
      frame_err    <= 1'b0;
      char_err     <= 1'b0;
    end else begin
      digit_valid  <= 1'b0;
      packet_valid <= 1'b0;
      char_err     <= 1'b0;
      frame_err    <= stop_err;

      if (busy) begin
        idle_cnt <= '0;
      end else if (idle_cnt != IDLE_W'(IDLE_LIMIT)) begin
        idle_cnt <= idle_cnt + IDLE_W'(1);
      end

      if (byte_valid) begin
        if (is_digit(rx_byte)) begin
          digits      <= (digits << 4) | DW'(rx_byte[3:0]);
          digit_valid <= 1'b1;
          if (digit_cnt == CNT_W'(NUM_DIGITS - 1)) begin
            packet_valid <= 1'b1;
            digit_cnt    <= '0;
          end else begin
            digit_cnt <= digit_cnt + CNT_W'(1);
          end
        end else begin
          char_err  <= 1'b1;
          digit_cnt <= '0;
        end
      end else if (idle_cnt == IDLE_W'(IDLE_LIMIT) && digit_cnt != '0) begin
        digit_cnt <= '0;
      end
    end
  end

endmodule
